prescaled_updown_counter: RTL

PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

---
 rtl/prescaled_updown_counter_if.sv | 24 ++
 rtl/prescaled_updown_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle for the prescaled up/down counter.
// Master drives key, mode and load; slave returns the count and its strobes.
interface prescaled_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             key1;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_out;
  logic             tick;
  logic             wrap;
  logic             dir_out;

  modport master (
    output key1, mode, load, load_value,
    input  count_out, tick, wrap, dir_out
  );

  modport slave (
    input  key1, mode, load, load_value,
    output count_out, tick, wrap, dir_out
  );
endinterface

// File: rtl/prescaled_updown_counter.sv
// Up/down counter stepped by a free-running prescaler, with a debounced direction key
// and wrap / saturate / bounce / hold behaviour at the limits.
module prescaled_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 5000000,
  parameter int DEBOUNCE = 50000
) (
  input logic                    clock_5,
  input logic                    reset,
  prescaled_updown_counter_if.slave bus
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [PSW-1:0]   PS_ONE  = PSW'(1);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0]   DB_ONE  = DBW'(1);
  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode;
  logic             ev;
  logic [PSW-1:0]   ps_q, ps_d;
  logic [1:0]       sync_q, sync_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             dir_q, dir_d;
  logic             bdir_q, bdir_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    ev       = (ps_q == PS_LAST);
    ps_d     = ev ? '0 : ps_q + PS_ONE;
    sync_d   = {sync_q[0], bus.key1};
    db_cnt_d = '0;
    dir_d    = dir_q;
    // Any cycle where the synchronized key agrees with the accepted direction restarts the count.
    if (sync_q[1] != dir_q) begin
      if (db_cnt_q == DB_LAST) dir_d = sync_q[1];
      else                     db_cnt_d = db_cnt_q + DB_ONE;
    end

    bdir_d = (mode == MODE_BOUNCE) ? bdir_q : dir_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (bus.load) begin
      cnt_d = bus.load_value;
    end else if (ev) begin
      tick_d = 1'b1;
      case (mode)
        MODE_WRAP: begin
          if (dir_q) begin
            cnt_d  = cnt_q + ONE;
            wrap_d = (cnt_q == MAX);
          end else begin
            cnt_d  = cnt_q - ONE;
            wrap_d = (cnt_q == '0);
          end
        end
        MODE_SAT: begin
          if (dir_q) begin
            if (cnt_q == MAX) wrap_d = 1'b1;
            else              cnt_d  = cnt_q + ONE;
          end else begin
            if (cnt_q == '0) wrap_d = 1'b1;
            else             cnt_d  = cnt_q - ONE;
          end
        end
        MODE_BOUNCE: begin
          if (bdir_q) begin
            if (cnt_q == MAX) begin
              cnt_d  = MAX - ONE;
              bdir_d = 1'b0;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d  = ONE;
              bdir_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_5 or posedge reset) begin
    if (reset) begin
      ps_q     <= '0;
      sync_q   <= '0;
      db_cnt_q <= '0;
      dir_q    <= 1'b1;
      bdir_q   <= 1'b1;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      dir_q    <= dir_d;
      bdir_q   <= bdir_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.count_out = cnt_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.dir_out   = (mode == MODE_BOUNCE) ? bdir_q : dir_q;

endmodule
